// File: rtl/rd_resp_reorder.sv
// rd_resp_reorder: tags outgoing reads with sequential IDs and collects the
// out-of-order responses into a tag-indexed buffer. Data goes back to the core
// strictly in request order, so the core's pairing of responses stays valid.
// The tag pool is tracked by an outstanding counter, which also separates the
// full case from the empty case when both pointers are equal.
`timescale 1ns/1ps
module rd_resp_reorder #(
    parameter int TAG_WIDTH  = 4,
    parameter int ADDR_WIDTH = 58,
    parameter int DATA_WIDTH = 512,
    parameter int AF_MARGIN  = 2
) (
    input  logic                  CLK_400M,
    input  logic                  reset_n,
    input  logic                  core_rd_valid,
    input  logic [ADDR_WIDTH-1:0] core_rd_addr,
    output logic                  core_rd_almostfull,
    output logic                  io_tx_rd_valid,
    output logic [ADDR_WIDTH-1:0] io_tx_rd_addr,
    output logic [TAG_WIDTH-1:0]  io_tx_rd_tag,
    input  logic                  spl_tx_rd_almostfull,
    input  logic                  io_rx_rd_valid,
    input  logic [TAG_WIDTH-1:0]  io_rx_rd_tag,
    input  logic [DATA_WIDTH-1:0] io_rx_data,
    output logic                  core_rx_rd_valid,
    output logic [DATA_WIDTH-1:0] core_rx_data,
    output logic [TAG_WIDTH:0]    outstanding,
    output logic                  err_sticky
);

    localparam int DEPTH = 1 << TAG_WIDTH;
    localparam logic [TAG_WIDTH:0]   DEPTH_CNT = (TAG_WIDTH+1)'(DEPTH);
    localparam logic [TAG_WIDTH:0]   AF_LEVEL  = (TAG_WIDTH+1)'(DEPTH - AF_MARGIN);
    localparam logic [TAG_WIDTH:0]   CNT_ONE   = (TAG_WIDTH+1)'(1);
    localparam logic [TAG_WIDTH-1:0] PTR_ONE   = TAG_WIDTH'(1);

    logic [TAG_WIDTH-1:0]  alloc_ptr_r;
    logic [TAG_WIDTH-1:0]  retire_ptr_r;
    logic [TAG_WIDTH:0]    outstanding_r;
    logic [DEPTH-1:0]      pending_r;
    logic [DEPTH-1:0]      valid_r;
    logic [DATA_WIDTH-1:0] buf_mem_r [DEPTH];

    logic                  io_tx_rd_valid_r;
    logic [ADDR_WIDTH-1:0] io_tx_rd_addr_r;
    logic [TAG_WIDTH-1:0]  io_tx_rd_tag_r;
    logic                  core_rx_rd_valid_r;
    logic [DATA_WIDTH-1:0] core_rx_data_r;
    logic                  err_r;

    logic                  alloc_s;
    logic                  overflow_s;
    logic                  capture_s;
    logic                  stray_s;
    logic                  retire_s;
    logic [DEPTH-1:0]      pending_nxt_s;
    logic [DEPTH-1:0]      valid_nxt_s;
    logic [TAG_WIDTH:0]    outstanding_nxt_s;

    // Per-cycle events: allocate, overflow drop, response capture/drop, in-order retire.
    always_comb begin
        alloc_s    = core_rd_valid && (outstanding_r != DEPTH_CNT);
        overflow_s = core_rd_valid && (outstanding_r == DEPTH_CNT);
        capture_s  = io_rx_rd_valid && pending_r[io_rx_rd_tag] && !valid_r[io_rx_rd_tag];
        stray_s    = io_rx_rd_valid && !(pending_r[io_rx_rd_tag] && !valid_r[io_rx_rd_tag]);
        retire_s   = valid_r[retire_ptr_r];
    end

    // Next state of the per-tag flags; retire clears, allocate/capture set.
    // Alloc and retire never hit the same tag in one cycle (that would need a full pool).
    always_comb begin
        pending_nxt_s = pending_r;
        valid_nxt_s   = valid_r;
        for (int i = 0; i < DEPTH; i++) begin
            pending_nxt_s[i] = (pending_r[i] && !(retire_s && (retire_ptr_r == TAG_WIDTH'(i))))
                             || (alloc_s && (alloc_ptr_r == TAG_WIDTH'(i)));
            valid_nxt_s[i]   = (valid_r[i] && !(retire_s && (retire_ptr_r == TAG_WIDTH'(i))))
                             || (capture_s && (io_rx_rd_tag == TAG_WIDTH'(i)));
        end
    end

    // Outstanding count: +1 on allocate, -1 on retire, unchanged when both occur.
    always_comb begin
        case ({alloc_s, retire_s})
            2'b10:   outstanding_nxt_s = outstanding_r + CNT_ONE;
            2'b01:   outstanding_nxt_s = outstanding_r - CNT_ONE;
            default: outstanding_nxt_s = outstanding_r;
        endcase
    end

    // Control state and registered outputs; synchronous active-low reset discards everything.
    always_ff @(posedge CLK_400M) begin
        if (!reset_n) begin
            alloc_ptr_r        <= '0;
            retire_ptr_r       <= '0;
            outstanding_r      <= '0;
            pending_r          <= '0;
            valid_r            <= '0;
            io_tx_rd_valid_r   <= 1'b0;
            io_tx_rd_addr_r    <= '0;
            io_tx_rd_tag_r     <= '0;
            core_rx_rd_valid_r <= 1'b0;
            core_rx_data_r     <= '0;
            err_r              <= 1'b0;
        end else begin
            pending_r          <= pending_nxt_s;
            valid_r            <= valid_nxt_s;
            outstanding_r      <= outstanding_nxt_s;
            io_tx_rd_valid_r   <= alloc_s;
            core_rx_rd_valid_r <= retire_s;
            err_r              <= err_r | overflow_s | stray_s;
            if (alloc_s) begin
                io_tx_rd_addr_r <= core_rd_addr;
                io_tx_rd_tag_r  <= alloc_ptr_r;
                alloc_ptr_r     <= alloc_ptr_r + PTR_ONE;
            end
            if (retire_s) begin
                core_rx_data_r <= buf_mem_r[retire_ptr_r];
                retire_ptr_r   <= retire_ptr_r + PTR_ONE;
            end
        end
    end

    // Response buffer write port; contents are qualified by valid_r, so no reset is needed.
    always_ff @(posedge CLK_400M) begin
        if (capture_s) begin
            buf_mem_r[io_rx_rd_tag] <= io_rx_data;
        end
    end

    assign core_rd_almostfull = spl_tx_rd_almostfull | (outstanding_r >= AF_LEVEL);
    assign io_tx_rd_valid     = io_tx_rd_valid_r;
    assign io_tx_rd_addr      = io_tx_rd_addr_r;
    assign io_tx_rd_tag       = io_tx_rd_tag_r;
    assign core_rx_rd_valid   = core_rx_rd_valid_r;
    assign core_rx_data       = core_rx_data_r;
    assign outstanding        = outstanding_r;
    assign err_sticky         = err_r;

endmodule
